encoder_4to2_queued: RTL and testbench

Sequential 4-to-2 encoder that converts one-hot or multi-hot request lines back into 2-bit indices, one per handshake. It is the inverse of the 2-to-4 one-hot decoder used elsewhere in the design. Requests are latched into a sticky pending register and issued one at a time on a valid/ready output. Priority is either fixed or round-robin.

---
 rtl/encoder_4to2_queued.sv | 92 +++++++++
 tb/tb_encoder_4to2_queued.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/encoder_4to2_queued.sv
// Queued 4-to-2 encoder: sticky pending requests are issued one index per
// valid/ready handshake, using fixed or round-robin priority.
module encoder_4to2_queued #(
    parameter bit RR_EN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    output logic [1:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] pending,
    output logic       ovf,
    output logic       busy
);

    logic [3:0] pending_q, pending_d;
    logic [1:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;
    logic [1:0] last_q, last_d;

    logic       free;
    logic       load;
    logic [1:0] sel;
    logic [3:0] clr;

    assign free = !valid_q || out_ready;
    assign load = free && (|pending_q);

    // Only already-pending bits compete; RR searches downward from last-1.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        sel   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        if (RR_EN) begin
            for (int k = 3; k >= 0; k--) begin
                idx = last_q + 2'(k);
                if (!found && pending_q[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            if (pending_q[3])      sel = 2'd3;
            else if (pending_q[2]) sel = 2'd2;
            else if (pending_q[1]) sel = 2'd1;
            else                   sel = 2'd0;
        end
    end

    always_comb begin
        clr       = load ? (4'b0001 << sel) : 4'b0000;
        pending_d = (pending_q & ~clr) | req_in;
        ovf_d     = |(req_in & pending_q & ~clr);
        code_d    = code_q;
        valid_d   = valid_q;
        last_d    = last_q;
        if (load) begin
            code_d  = sel;
            valid_d = 1'b1;
            last_d  = sel;
        end else if (free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 4'b0000;
            code_q    <= 2'b00;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            last_q    <= 2'd0;
        end else begin
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            last_q    <= last_d;
        end
    end

    assign out_code  = code_q;
    assign out_valid = valid_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;
    assign busy      = valid_q || (|pending_q);

endmodule

// File: tb/tb_encoder_4to2_queued.sv
// Directed bench for encoder_4to2_queued: one fixed-priority and one
// round-robin instance share the same stimulus.
module tb_encoder_4to2_queued;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_in = 4'b0000;
    logic       out_ready = 1'b0;

    logic [1:0] fpCode, rrCode;
    logic       fpValid, rrValid;
    logic [3:0] fpPending, rrPending;
    logic       fpOvf, rrOvf;
    logic       fpBusy, rrBusy;

    int checks = 0;
    int failures = 0;

    encoder_4to2_queued #(.RR_EN(1'b0)) dutFixed (
        .clk(clk), .rst(rst), .req_in(req_in),
        .out_code(fpCode), .out_valid(fpValid), .out_ready(out_ready),
        .pending(fpPending), .ovf(fpOvf), .busy(fpBusy)
    );

    encoder_4to2_queued #(.RR_EN(1'b1)) dutRr (
        .clk(clk), .rst(rst), .req_in(req_in),
        .out_code(rrCode), .out_valid(rrValid), .out_ready(out_ready),
        .pending(rrPending), .ovf(rrOvf), .busy(rrBusy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] req, input logic rdy);
        rst       = r;
        req_in    = req;
        out_ready = rdy;
    endtask

    // Checks a full fixed-priority output snapshot.
    task automatic checkFixed(input string tag, input logic v, input logic [1:0] c,
                              input logic [3:0] p, input logic o);
        checkOutput({tag, ".valid"}, 8'(fpValid), 8'(v));
        if (v) checkOutput({tag, ".code"}, 8'(fpCode), 8'(c));
        checkOutput({tag, ".pending"}, 8'(fpPending), 8'(p));
        checkOutput({tag, ".ovf"}, 8'(fpOvf), 8'(o));
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 4'b0000, 1'b0);
        tick();
        checkFixed("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        checkOutput("reset.code", 8'(fpCode), 8'd0);
        checkOutput("reset.busy", 8'(fpBusy), 8'd0);
        checkOutput("reset.rrValid", 8'(rrValid), 8'd0);

        // 1: single request, 2-cycle latency, one issue
        applyStimulus(1'b0, 4'b0100, 1'b1);
        tick();
        checkFixed("t1.c1", 1'b0, 2'd0, 4'b0100, 1'b0);
        checkOutput("t1.c1.busy", 8'(fpBusy), 8'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        tick();
        checkFixed("t1.c2", 1'b1, 2'd2, 4'b0000, 1'b0);
        tick();
        checkFixed("t1.c3", 1'b0, 2'd0, 4'b0000, 1'b0);
        checkOutput("t1.c3.busy", 8'(fpBusy), 8'd0);

        // 2: multi-hot burst, fixed priority
        applyStimulus(1'b0, 4'b1011, 1'b1);
        tick();
        checkFixed("t2.c1", 1'b0, 2'd0, 4'b1011, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        tick();
        checkFixed("t2.c2", 1'b1, 2'd3, 4'b0011, 1'b0);
        tick();
        checkFixed("t2.c3", 1'b1, 2'd1, 4'b0001, 1'b0);
        tick();
        checkFixed("t2.c4", 1'b1, 2'd0, 4'b0000, 1'b0);
        tick();
        checkFixed("t2.c5", 1'b0, 2'd0, 4'b0000, 1'b0);

        // 3: round robin with all requests held for 8 cycles
        applyStimulus(1'b1, 4'b0000, 1'b1);
        tick();
        applyStimulus(1'b0, 4'b1111, 1'b1);
        tick();
        checkOutput("t3.pending", 8'(rrPending), 8'hF);
        checkOutput("t3.valid0", 8'(rrValid), 8'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) req_in = 4'b0000;
            tick();
            checkOutput($sformatf("t3.valid%0d", i), 8'(rrValid), 8'd1);
            checkOutput($sformatf("t3.code%0d", i), 8'(rrCode), 8'(2'd3 - 2'(i)));
            // Fixed priority keeps re-serving the always-refilled top bit
            checkOutput($sformatf("t3.fpCode%0d", i), 8'(fpCode), 8'd3);
        end

        // 4: backpressure, re-pend and overflow
        applyStimulus(1'b1, 4'b0000, 1'b0);
        tick();
        applyStimulus(1'b0, 4'b0001, 1'b0);
        tick();
        checkFixed("t4.c0", 1'b0, 2'd0, 4'b0001, 1'b0);
        req_in = 4'b0000;
        tick();
        checkFixed("t4.c1", 1'b1, 2'd0, 4'b0000, 1'b0);
        tick();
        checkFixed("t4.c2", 1'b1, 2'd0, 4'b0000, 1'b0);
        req_in = 4'b0001;
        tick();
        checkFixed("t4.c3", 1'b1, 2'd0, 4'b0001, 1'b0);
        tick();
        checkFixed("t4.c4", 1'b1, 2'd0, 4'b0001, 1'b1);
        req_in = 4'b0000;
        tick();
        checkFixed("t4.c5", 1'b1, 2'd0, 4'b0001, 1'b0);
        out_ready = 1'b1;
        tick();
        checkFixed("t4.x1", 1'b1, 2'd0, 4'b0000, 1'b0);
        tick();
        checkFixed("t4.x2", 1'b0, 2'd0, 4'b0000, 1'b0);

        // 5: request for the index being loaded re-pends without overflow
        applyStimulus(1'b1, 4'b0000, 1'b1);
        tick();
        applyStimulus(1'b0, 4'b1000, 1'b1);
        tick();
        checkFixed("t5.c1", 1'b0, 2'd0, 4'b1000, 1'b0);
        tick();
        checkFixed("t5.c2", 1'b1, 2'd3, 4'b1000, 1'b0);
        req_in = 4'b0000;
        tick();
        checkFixed("t5.c3", 1'b1, 2'd3, 4'b0000, 1'b0);
        tick();
        checkFixed("t5.c4", 1'b0, 2'd0, 4'b0000, 1'b0);

        // 6: reset mid-operation, then fresh request
        applyStimulus(1'b0, 4'b1000, 1'b0);
        tick();
        req_in = 4'b0110;
        tick();
        checkFixed("t6.pre", 1'b1, 2'd3, 4'b0110, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b1);
        tick();
        checkFixed("t6.rst", 1'b0, 2'd0, 4'b0000, 1'b0);
        checkOutput("t6.rst.code", 8'(fpCode), 8'd0);
        checkOutput("t6.rst.busy", 8'(fpBusy), 8'd0);
        checkOutput("t6.rst.rrBusy", 8'(rrBusy), 8'd0);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        tick();
        checkFixed("t6.c1", 1'b0, 2'd0, 4'b0010, 1'b0);
        req_in = 4'b0000;
        tick();
        checkFixed("t6.c2", 1'b1, 2'd1, 4'b0000, 1'b0);
        checkOutput("t6.c2.rrCode", 8'(rrCode), 8'd1);
        checkOutput("t6.c2.rrOvf", 8'(rrOvf), 8'd0);
        tick();
        checkFixed("t6.c3", 1'b0, 2'd0, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
